relu_maxpool_2x2: RTL and testbench

- Stage directly downstream of the 5x5 convolution block; consumes its 32-bit raster-order output stream (`invalid` = 0 marks a good sample).
- Per sample: ReLU, then fixed-point rescale to 16 bits with saturation.
- Then 2x2 stride-2 max pooling using a half-row line buffer.
- Emits pooled 16-bit pixels with a one-cycle valid strobe for the next conv layer.

---
 rtl/relu_maxpool_2x2.sv | 146 ++++++++++++++
 tb/tb_relu_maxpool_2x2.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/relu_maxpool_2x2.sv
// relu_maxpool_2x2: ReLU, fixed-point rescale with saturation, then 2x2
// stride-2 max pooling over a raster-order sample stream.
// Optional macro POOL_ROUND_EN: round half up before the shift instead of
// truncating. The interface is identical with or without it.
module relu_maxpool_2x2 #(
  parameter int unsigned IN_BITS   = 32,
  parameter int unsigned OUT_BITS  = 16,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned IN_HEIGHT = 8,
  parameter int unsigned SHIFT     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IN_BITS-1:0]  in_data,
  input  logic                in_invalid,
  input  logic                in_finish,
  output logic [OUT_BITS-1:0] out_data,
  output logic                out_valid,
  output logic                frame_done,
  output logic                frame_err
);

  localparam int unsigned CW   = (IN_WIDTH  > 2) ? $clog2(IN_WIDTH)  : 1;
  localparam int unsigned RW   = (IN_HEIGHT > 2) ? $clog2(IN_HEIGHT) : 1;
  localparam int unsigned HALF = IN_WIDTH / 2;
  localparam int unsigned HW   = (CW > 1) ? CW - 1 : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);

  localparam logic [IN_BITS:0] MAX_WIDE = (IN_BITS+1)'((64'd1 << (OUT_BITS - 1)) - 64'd1);

`ifdef POOL_ROUND_EN
  localparam int unsigned      RND_POS = (SHIFT >= 1) ? SHIFT - 1 : 0;
  localparam logic [IN_BITS:0] RND     = (SHIFT >= 1) ? ((IN_BITS+1)'(1) << RND_POS) : '0;
`endif

  localparam logic [1:0] ROW_EVEN = 2'd0;
  localparam logic [1:0] ROW_ODD  = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;

  logic [1:0]          state, state_next;
  logic [CW-1:0]       col, col_next;
  logic [RW-1:0]       row, row_next;
  logic [OUT_BITS-1:0] hold;
  logic [OUT_BITS-1:0] line_buf [HALF];

  logic                accept;
  logic                last_accept;
  logic                started;
  logic [HW-1:0]       half;
  logic [IN_BITS-1:0]  v;
  logic [IN_BITS:0]    wide;
  logic [IN_BITS:0]    wide_sh;
  logic [OUT_BITS-1:0] x;

  function automatic logic [OUT_BITS-1:0] smax(input logic [OUT_BITS-1:0] a,
                                               input logic [OUT_BITS-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  assign accept      = !in_invalid && (state != DONE);
  assign last_accept = accept && (row == ROW_LAST) && (col == COL_LAST);
  assign started     = (col != '0) || (row != '0);
  assign half        = HW'(col >> 1);

  // ReLU, optional rounding, shift and saturation of the incoming sample
  always_comb begin
    v = in_data[IN_BITS-1] ? '0 : in_data;
`ifdef POOL_ROUND_EN
    wide = {1'b0, v} + RND;
`else
    wide = {1'b0, v};
`endif
    wide_sh = wide >> SHIFT;
    x = (wide_sh > MAX_WIDE) ? OUT_BITS'(MAX_WIDE) : wide_sh[OUT_BITS-1:0];
  end

  // Raster position and row-parity state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ROW_EVEN;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_next;
      col   <= col_next;
      row   <= row_next;
    end
  end

  // Next raster position; DONE is terminal until reset
  always_comb begin
    state_next = state;
    col_next   = col;
    row_next   = row;
    if (accept) begin
      if (col == COL_LAST) begin
        col_next = '0;
        if (row == ROW_LAST) begin
          state_next = DONE;
        end else begin
          row_next   = row + RW'(1);
          state_next = (state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
        end
      end else begin
        col_next = col + CW'(1);
      end
    end
  end

  // Pooling datapath, output strobe and frame status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        if (state == ROW_EVEN) begin
          if (!col[0]) hold <= x;
        end else begin
          if (!col[0]) begin
            hold <= smax(line_buf[half], x);
          end else begin
            out_data  <= smax(hold, x);
            out_valid <= 1'b1;
          end
        end
      end
      if (last_accept) frame_done <= 1'b1;
      if (in_finish && (state != DONE) && started && !last_accept) frame_err <= 1'b1;
    end
  end

  // Half-row buffer holding the horizontal max of each even-row pair
  always_ff @(posedge clk) begin
    if (!reset && accept && (state == ROW_EVEN) && col[0]) begin
      line_buf[half] <= smax(hold, x);
    end
  end

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Directed bench for relu_maxpool_2x2 (8x8 frame, SHIFT=8).
module tb_relu_maxpool_2x2;

  localparam int K_RAMP = 0;
  localparam int K_RELU = 1;
  localparam int K_SAT  = 2;
  localparam int K_HALF = 3;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic        in_invalid;
  logic        in_finish;
  logic [15:0] out_data;
  logic        out_valid;
  logic        frame_done;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  relu_maxpool_2x2 dut (
    .clk        (clk),
    .reset      (reset),
    .in_data    (in_data),
    .in_invalid (in_invalid),
    .in_finish  (in_finish),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic inv, input logic fin);
    in_data    = d;
    in_invalid = inv;
    in_finish  = fin;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      send($urandom(), 1'b0, 1'b0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
    end
    reset = 1'b0;
  endtask

  function automatic logic [31:0] sample_val(input int kind, input int idx);
    case (kind)
      K_RELU:  return -32'sd1000;
      K_SAT:   return (idx == 0) ? 32'h7FFF_FFFF : 32'(idx) << 8;
      K_HALF:  return 32'h180;
      default: return 32'(idx) << 8;
    endcase
  endfunction

  // Hand-derived pooled values: ramp window max is the bottom-right sample
  function automatic logic [31:0] exp_val(input int kind, input int k);
    int i;
    int j;
    i = k / 4;
    j = k % 4;
    case (kind)
      K_RELU:  return 32'd0;
      K_SAT:   return (k == 0) ? 32'h7FFF : 32'((2*i+1)*8 + 2*j + 1);
`ifdef POOL_ROUND_EN
      K_HALF:  return 32'd2;
`else
      K_HALF:  return 32'd1;
`endif
      default: return 32'((2*i+1)*8 + 2*j + 1);
    endcase
  endfunction

  task automatic run_frame(input int kind, input bit gaps, input int nsamp, input bit fin_last);
    int k;
    int r;
    int c;
    k = 0;
    for (int idx = 0; idx < nsamp; idx++) begin
      if (gaps) begin
        for (int g = 0; g < 4 && $urandom_range(1) == 0; g++) begin
          send($urandom(), 1'b1, 1'b0);
          chk("gap_no_strobe", 32'(out_valid), 32'd0);
        end
      end
      send(sample_val(kind, idx), 1'b0, fin_last && (idx == nsamp - 1));
      r = idx / 8;
      c = idx % 8;
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        chk("strobe", 32'(out_valid), 32'd1);
        chk("pool_data", 32'(out_data), exp_val(kind, k));
        k++;
      end else begin
        chk("no_strobe", 32'(out_valid), 32'd0);
      end
      chk("frame_done", 32'(frame_done), 32'(idx == 63));
      chk("frame_err_clear", 32'(frame_err), 32'd0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    in_data    = '0;
    in_invalid = 1'b1;
    in_finish  = 1'b0;

    // Reset held with live input
    do_reset(3);

    // Ramp frame, in_finish coincident with the final accept
    run_frame(K_RAMP, 1'b0, 64, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send(32'h1000, 1'b0, i[0]);
      chk("done_no_strobe", 32'(out_valid), 32'd0);
      chk("done_level", 32'(frame_done), 32'd1);
      chk("done_no_err", 32'(frame_err), 32'd0);
    end

    // ReLU clamps negatives to zero
    do_reset(1);
    run_frame(K_RELU, 1'b0, 64, 1'b0);

    // Saturation of the first sample
    do_reset(1);
    run_frame(K_SAT, 1'b0, 64, 1'b0);

    // Random gaps between samples
    do_reset(1);
    run_frame(K_RAMP, 1'b1, 64, 1'b0);

    // Early finish after 30 samples
    do_reset(1);
    run_frame(K_RAMP, 1'b0, 30, 1'b0);
    send(32'h0, 1'b1, 1'b1);
    chk("early_err_set", 32'(frame_err), 32'd1);
    for (int i = 0; i < 4; i++) begin
      send(32'(30 + i) << 8, 1'b0, 1'b0);
      chk("early_err_sticky", 32'(frame_err), 32'd1);
    end
    do_reset(1);
    chk("early_err_cleared", 32'(frame_err), 32'd0);

    // Reset after 20 samples, with an accept in the reset cycle
    run_frame(K_RAMP, 1'b0, 20, 1'b0);
    reset = 1'b1;
    send(32'h7FFF_FFFF, 1'b0, 1'b0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    reset = 1'b0;
    run_frame(K_RAMP, 1'b0, 64, 1'b0);

    // Constant 0x180: rounding versus truncation
    do_reset(1);
    run_frame(K_HALF, 1'b0, 64, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
